add_sub_serial: RTL and testbench
=================================

# add_sub_serial

Multi-cycle, runtime-selectable adder/subtractor. It processes WIDTH-bit operands in SLICE-bit digits, LSB slice first, one slice per clock, through a single shared slice adder. It wraps the result in valid/ready handshakes on both sides and adds signed overflow detection. It is the area-reduced, parametrised successor to the combinational add/sub datapath, intended for the ALU's wide-operand path.

## Interface
- WIDTH, 16, operand/result width in bits
- SLICE, 4, bits processed per cycle; must divide WIDTH; N = WIDTH/SLICE cycles per operation

- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_valid  input  1  request valid
- o_ready  output  1  block can accept a request (high only in IDLE)
- i_op1  input  WIDTH  minuend / first addend
- i_op2  input  WIDTH  subtrahend / second addend
- i_sub  input  1  0 = add, 1 = subtract (sampled with request)
- i_carry_borrow  input  1  carry-in (add) or borrow-in (sub)
- o_valid  output  1  result valid
- i_ready  input  1  consumer accepts result
- o_res  output  WIDTH  result
- o_carry_borrow  output  1  carry-out (add) or borrow-out (sub)
- o_overflow  output  1  two's-complement signed overflow
- o_busy  output  1  high in CALC or DONE

## Operation
- States: IDLE, CALC, DONE.
- IDLE: o_ready=1. On i_valid&&o_ready, perform the following and go to CALC:
  - latch i_op1
  - latch operand b = i_sub ? ~i_op2 : i_op2
  - latch initial carry c = i_sub ? ~i_carry_borrow : i_carry_borrow
  - clear the slice counter
- CALC: each cycle, add slice k of op1 and b plus the running carry, write slice k of the result register, update the carry, and increment k.
  - After slice N-1, go to DONE.
  - On the final slice, register the flags:
    - o_carry_borrow = i_sub ? ~carry_out : carry_out
    - o_overflow = (op1[MSB] == b[MSB]) && (res[MSB] != op1[MSB])
- DONE: o_valid=1, with o_res and flags held stable. On i_valid... no: on o_valid&&i_ready, go to IDLE. A new request is not accepted in the same cycle.
- Arithmetic is modulo 2^WIDTH. Sub computes op1 − op2 − borrow_in.
- i_valid while o_ready=0 is ignored; requests are not queued.
- Inputs other than the handshake are don't-care outside the accept cycle.
- SLICE not dividing WIDTH, or SLICE > WIDTH, is an elaboration-time fatal error.

## Timing
- Reset (async assert, sync-safe deassert) sets:
  - state=IDLE
  - o_ready=1, o_valid=0, o_busy=0
  - o_res=0, o_carry_borrow=0, o_overflow=0
- Latency: accept at edge E0. Slices are processed at edges E1..EN. o_valid is high after edge EN, i.e. N cycles after the accept edge.
- Throughput with i_ready held high: one operation per N+2 cycles.
- N=1 (SLICE=WIDTH) is legal: one CALC cycle.
- o_res and flags change only on the final CALC edge or on reset. They stay stable through DONE and IDLE until the next final slice.
- Reset mid-CALC or mid-DONE aborts the operation immediately, with no o_valid pulse. The block is ready again on the first edge after deassertion.
- o_ready and o_busy are decoded from registered state (no combinational path from i_valid/i_ready).

## Structure
- Package add_sub_pkg: state enum (IDLE, CALC, DONE) and mode constants (MODE_ADD=0, MODE_SUB=1).
- Sub-module add_slice: SLICE-bit ripple adder built from the existing full-adder cell, with ports for a, b, carry-in, sum and carry-out. Instantiate exactly one.
- Top holds:
  - the FSM
  - the slice counter ($clog2(N) bits, minimum 1)
  - the operand, result and carry registers

## Test plan
- Add 0x1234 + 0x0FFF, cin=0 (WIDTH=16, SLICE=4) -> o_res=0x2233, carry=0, ovf=0. o_valid rises exactly 4 cycles after the accept edge.
- Sub 0x0005 − 0x0007, bin=0 -> o_res=0xFFFE, borrow=1, ovf=0. Sub 0x0007 − 0x0005, bin=1 -> 0x0001, borrow=0.
- Add 0x7FFF + 0x0001 -> 0x8000, carry=0, ovf=1. Sub 0x8000 − 0x0001 -> 0x7FFF, borrow=0, ovf=1. Add 0xFFFF + 0x0001 -> 0x0000, carry=1, ovf=0.
- Backpressure: hold i_ready=0 for 10 cycles in DONE while pulsing i_valid -> o_valid, o_res and flags stay stable, o_ready=0, the new request is dropped. After i_ready=1, o_ready=1 on the next cycle.
- Assert i_rst_n=0 during CALC slice 2 -> all outputs at reset values immediately, and no o_valid. The next request, 0x00FF + 0x0001, returns 0x0100.
- SLICE=WIDTH=8 build: add 0x80 + 0x80 -> 0x00, carry=1, ovf=1, with o_valid 1 cycle after accept.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared types and constants for the serial add/sub datapath.
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/add_slice.sv
// SLICE-bit ripple-carry adder built from full_adder cells.
module add_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             c_i,
  output logic [SLICE-1:0] s_o,
  output logic             c_o
);

  logic [SLICE:0] carry;

  assign carry[0] = c_i;
  assign c_o      = carry[SLICE];

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (carry[i]),
      .s_o (s_o[i]),
      .c_o (carry[i+1])
    );
  end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the slice ripple adder.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/add_sub_serial.sv
// Digit-serial adder/subtractor: one SLICE-bit digit per clock through a single
// shared slice adder, with valid/ready on both sides and signed overflow.
module add_sub_serial
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic             i_sub,
  input  logic             i_carry_borrow,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_res,
  output logic             o_carry_borrow,
  output logic             o_overflow,
  output logic             o_busy,
  output logic [1:0]       o_dbg_state
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
    $fatal(1, "add_sub_serial: SLICE must divide WIDTH and not exceed it");
  end

  // Handshake: a request transfers on a rising edge with i_valid && o_ready;
  // a result transfers on a rising edge with o_valid && i_ready. Both ready
  // and valid are decoded from registered state only.

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  op1_q, op1_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              carry_q, carry_d;
  logic              sub_q, sub_d;
  logic              cb_q, cb_d;
  logic              ovf_q, ovf_d;

  logic [SLICE-1:0]  a_s, b_s, sum_s;
  logic              c_out;
  logic [WIDTH-1:0]  res_next;

  assign a_s = op1_q[int'(cnt_q)*SLICE +: SLICE];
  assign b_s = b_q[int'(cnt_q)*SLICE +: SLICE];

  add_slice #(.SLICE(SLICE)) u_slice (
    .a_i (a_s),
    .b_i (b_s),
    .c_i (carry_q),
    .s_o (sum_s),
    .c_o (c_out)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op1_d    = op1_q;
    b_d      = b_q;
    work_d   = work_q;
    res_d    = res_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    cb_d     = cb_q;
    ovf_d    = ovf_q;
    res_next = work_q;
    res_next[int'(cnt_q)*SLICE +: SLICE] = sum_s;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          // Subtraction is op1 + ~op2 + ~borrow_in.
          op1_d   = i_op1;
          b_d     = (i_sub == MODE_SUB) ? ~i_op2 : i_op2;
          carry_d = (i_sub == MODE_SUB) ? ~i_carry_borrow : i_carry_borrow;
          sub_d   = i_sub;
          cnt_d   = '0;
          work_d  = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        work_d  = res_next;
        carry_d = c_out;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          res_d   = res_next;
          cb_d    = (sub_q == MODE_SUB) ? ~c_out : c_out;
          ovf_d   = (op1_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (res_next[WIDTH-1] != op1_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op1_q   <= '0;
      b_q     <= '0;
      work_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= MODE_ADD;
      cb_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      b_q     <= b_d;
      work_q  <= work_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      cb_q    <= cb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_ready        = (state_q == IDLE);
  assign o_valid        = (state_q == DONE);
  assign o_busy         = (state_q != IDLE);
  assign o_res          = res_q;
  assign o_carry_borrow = cb_q;
  assign o_overflow     = ovf_q;
  assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// Bench for add_sub_serial: 16/4 instance for vectors, backpressure and reset
// abort, plus an 8/8 instance for the single-cycle build.
module tb_add_sub_serial;

  localparam int W = 16;

  logic clk;
  logic rst_n;

  // 16-bit, 4-bit slice instance
  logic         valid_i, ready_i, sub_i, cin_i;
  logic [W-1:0] op1_i, op2_i;
  logic         ready_o, valid_o, cb_o, ovf_o, busy_o;
  logic [W-1:0] res_o;
  logic [1:0]   st_o;

  // 8-bit, single-slice instance
  logic         v2_valid_i, v2_ready_i, v2_sub_i, v2_cin_i;
  logic [7:0]   v2_op1_i, v2_op2_i;
  logic         v2_ready_o, v2_valid_o, v2_cb_o, v2_ovf_o, v2_busy_o;
  logic [7:0]   v2_res_o;
  logic [1:0]   v2_st_o;

  add_sub_serial #(.WIDTH(16), .SLICE(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_i), .o_ready(ready_o),
    .i_op1(op1_i), .i_op2(op2_i), .i_sub(sub_i), .i_carry_borrow(cin_i),
    .o_valid(valid_o), .i_ready(ready_i), .o_res(res_o),
    .o_carry_borrow(cb_o), .o_overflow(ovf_o), .o_busy(busy_o),
    .o_dbg_state(st_o)
  );

  add_sub_serial #(.WIDTH(8), .SLICE(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v2_valid_i), .o_ready(v2_ready_o),
    .i_op1(v2_op1_i), .i_op2(v2_op2_i), .i_sub(v2_sub_i),
    .i_carry_borrow(v2_cin_i), .o_valid(v2_valid_o), .i_ready(v2_ready_i),
    .o_res(v2_res_o), .o_carry_borrow(v2_cb_o), .o_overflow(v2_ovf_o),
    .o_busy(v2_busy_o), .o_dbg_state(v2_st_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // {carry_borrow, overflow, result}
  logic [W+1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] res;
    logic         cb;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub, input logic cin);
    logic [W:0] f;
    logic       ovf;
    if (!sub) begin
      f   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      ovf = (a[W-1] == b[W-1]) && (f[W-1] != a[W-1]);
    end else begin
      f   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
      ovf = (a[W-1] != b[W-1]) && (f[W-1] != a[W-1]);
    end
    return {f[W], ovf, f[W-1:0]};
  endfunction

  // driver: issue one request, push its expectation, wait for and score the result
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin, input logic [W+1:0] exp);
    int cyc;
    logic [W+1:0] e;
    cyc = 0;
    while (!ready_o && cyc < 40) begin @(posedge clk); #1; cyc++; end
    @(negedge clk);
    check("ready_before_accept", ready_o, 1);
    op1_i = a; op2_i = b; sub_i = sub; cin_i = cin; valid_i = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("busy_in_calc", {ready_o, busy_o}, 2'b01);
    cyc = 0;
    while (!valid_o && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("latency", cyc, 4);
    if (exp_q.size() == 0) begin
      check("queue_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("res", res_o, e[W-1:0]);
      check("carry_borrow", cb_o, e[W+1]);
      check("overflow", ovf_o, e[W]);
    end
    @(posedge clk); #1;
    check("ready_after_handshake", {ready_o, valid_o}, 2'b10);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    vecs[2] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0;
    valid_i = 1'b0; ready_i = 1'b1; sub_i = 1'b0; cin_i = 1'b0;
    op1_i = '0; op2_i = '0;
    v2_valid_i = 1'b0; v2_ready_i = 1'b1; v2_sub_i = 1'b0; v2_cin_i = 1'b0;
    v2_op1_i = '0; v2_op2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {ready_o, valid_o, busy_o, cb_o, ovf_o, res_o},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
             {vecs[i].cb, vecs[i].ovf, vecs[i].res});

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] a, b;
      logic s, c;
      a = W'($urandom_range(0, 16'hFFFF));
      b = W'($urandom_range(0, 16'hFFFF));
      s = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      run_op(a, b, s, c, model(a, b, s, c));
    end

    // backpressure: result held, extra requests dropped
    begin
      int cyc;
      @(negedge clk);
      ready_i = 1'b0;
      op1_i = 16'h4000; op2_i = 16'h4000; sub_i = 1'b0; cin_i = 1'b0; valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      cyc = 0;
      while (!valid_o && cyc < 40) begin @(posedge clk); #1; cyc++; end
      check("bp_latency", cyc, 4);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        valid_i = k[0];
        op1_i = 16'h0101 * k[15:0]; op2_i = 16'h0003; sub_i = 1'b1;
        check("bp_hold", {valid_o, ready_o, cb_o, ovf_o, res_o},
              {1'b1, 1'b0, 1'b0, 1'b1, 16'h8000});
      end
      @(negedge clk);
      valid_i = 1'b0;
      ready_i = 1'b1;
      @(posedge clk); #1;
      check("bp_release", {ready_o, valid_o}, 2'b10);
      cyc = 0;
      for (int k = 0; k < 8; k++) begin @(posedge clk); #1; if (valid_o) cyc++; end
      check("bp_dropped", cyc, 0);
    end

    // reset while processing slice 2 aborts without a result
    begin
      int cyc;
      @(negedge clk);
      op1_i = 16'h1111; op2_i = 16'h2222; sub_i = 1'b0; cin_i = 1'b0; valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("abort_outputs", {ready_o, valid_o, busy_o, cb_o, ovf_o, res_o},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort_ready", ready_o, 1);
      cyc = 0;
      for (int k = 0; k < 8; k++) begin @(posedge clk); #1; if (valid_o) cyc++; end
      check("abort_no_valid", cyc, 0);
      run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0100});
    end

    // single-slice build
    begin
      int cyc;
      @(negedge clk);
      check("n1_ready", v2_ready_o, 1);
      v2_op1_i = 8'h80; v2_op2_i = 8'h80; v2_sub_i = 1'b0; v2_cin_i = 1'b0; v2_valid_i = 1'b1;
      @(posedge clk); #1;
      v2_valid_i = 1'b0;
      cyc = 0;
      while (!v2_valid_o && cyc < 40) begin @(posedge clk); #1; cyc++; end
      check("n1_latency", cyc, 1);
      check("n1_result", {v2_cb_o, v2_ovf_o, v2_res_o}, {1'b1, 1'b1, 8'h00});
      @(posedge clk); #1;
      check("n1_ready_after", {v2_ready_o, v2_valid_o}, 2'b10);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
